// File: rtl/rf_pkg.sv
// Shared definitions for the register-file port arbiter: widths, arbitration
// mode, lock FSM states and the read-return tag carried alongside each read.
package rf_pkg;

  localparam int RF_ADDR_W      = 10;
  localparam int RF_DATA_W      = 1408;
  localparam int RF_MAX_CLIENTS = 8;
  localparam int RF_TAG_ID_W    = $clog2(RF_MAX_CLIENTS);

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // One stage of the read-return pipeline: which client the RAM data belongs to.
  typedef struct packed {
    logic                   valid;
    logic [RF_TAG_ID_W-1:0] id;
  } rd_tag_t;

  // Index following idx, wrapping modulo n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker: the first set request at or after
// start (wrapping) wins. A start of 0 gives plain lowest-index priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  // NOTE: combinational logic uses blocking assignments, and every output gets
  // a default before the loop so no path leaves a value held (no latch).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(start) + k) % N);
      if (!valid && req[pos]) begin
        valid    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the single register-file RAM port among NUM_CLIENTS engines with
// fixed-priority or round-robin arbitration, burst locking and tagged read return.
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int DATA_W      = RF_DATA_W,
  parameter int RD_LAT      = 1,
  parameter int ARB_MODE    = 1,
  parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        lock,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_data,
  output logic                          ram_we,
  output logic                          ram_re,
  input  logic [DATA_W-1:0]             ram_q,
  output logic                          busy
);

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_valid;
  logic [ID_W-1:0]        pick_start;

  logic                   gnt_any;
  logic [ID_W-1:0]        gnt_idx;

  logic [ADDR_W-1:0]      addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0]      wdata_arr [NUM_CLIENTS];

  rd_tag_t                tag_in;
  rd_tag_t                tag_q [RD_LAT];
  rd_tag_t                tail;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Fixed priority is the same search anchored at client 0.
  assign pick_start = (ARB_MODE == int'(ARB_RR)) ? rr_ptr_q : '0;

  rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Lock FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Lock FSM: next state. A lock is taken only by the client actually granted.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          rr_ptr_d = ID_W'(wrap_inc(int'(gnt_idx), NUM_CLIENTS));
          if (lock[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      LOCKED: begin
        // Released by a final unlocked beat or by the owner walking away.
        if (!req[owner_q] || !lock[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock FSM: outputs. Grant stays combinational from req even during reset.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_q == LOCKED) begin
      if (req[owner_q]) begin
        gnt[owner_q] = 1'b1;
        gnt_any      = 1'b1;
        gnt_idx      = owner_q;
      end
    end else begin
      gnt     = pick_gnt;
      gnt_any = pick_valid;
      gnt_idx = pick_idx;
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (gnt_any) begin
      ram_addr = addr_arr[gnt_idx];
      ram_data = wdata_arr[gnt_idx];
      ram_we   = we[gnt_idx];
      ram_re   = ~we[gnt_idx];
    end
  end

  always_comb begin
    tag_in.valid = gnt_any & ~we[gnt_idx];
    tag_in.id    = RF_TAG_ID_W'(gnt_idx);
  end

  // NOTE: the tag pipeline is a handful of flops, so it is reset outright; a
  // reset mid-flight must kill outstanding returns. The RAM data path itself
  // carries no storage here and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail  = tag_q[RD_LAT-1];
  assign rdata = ram_q;

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (tail.valid && tail.id == RF_TAG_ID_W'(i)) rvalid[i] = 1'b1;
    end
  end

  always_comb begin
    busy = (state_q == LOCKED);
    for (int i = 0; i < RD_LAT; i++) busy = busy | tag_q[i].valid;
  end

  gnt_onehot_a : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  gnt_req_a    : assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: a round-robin instance (RD_LAT=2) and a fixed
// priority instance (RD_LAT=1) share stimulus and are checked against a model.
module tb_rf_port_arbiter;
  import rf_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int DW   = 64;
  localparam int NDUT = 2;

  typedef struct {
    int            d;
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, lock, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;

  logic [N-1:0]      gnt_o    [NDUT];
  logic [N-1:0]      rvalid_o [NDUT];
  logic [DW-1:0]     rdata_o  [NDUT];
  logic [AW-1:0]     ram_addr_o [NDUT];
  logic [DW-1:0]     ram_data_o [NDUT];
  logic              ram_we_o [NDUT];
  logic              ram_re_o [NDUT];
  logic [DW-1:0]     ram_q_i  [NDUT];
  logic              busy_o   [NDUT];

  logic [DW-1:0]     mem    [NDUT][16];
  logic [DW-1:0]     q_pipe [NDUT][2];

  // Reference model state
  int                m_owner [NDUT];
  int                m_ptr   [NDUT];
  logic [DW-1:0]     m_mem   [NDUT][16];
  rd_exp_t           pend [$];
  int                cyc;

  int                e_g     [NDUT];
  logic [N-1:0]      e_gnt   [NDUT];
  logic [N-1:0]      e_rv    [NDUT];
  logic [AW-1:0]     e_addr  [NDUT];
  logic [DW-1:0]     e_wd    [NDUT];
  logic [DW-1:0]     e_rd    [NDUT];
  logic              e_we    [NDUT];
  logic              e_re    [NDUT];
  logic              e_busy  [NDUT];

  int                n_cmp = 0;
  int                n_bad = 0;

  always #5 clk = ~clk;

  rf_port_arbiter #(
    .NUM_CLIENTS (N), .ADDR_W (AW), .DATA_W (DW), .RD_LAT (2), .ARB_MODE (1)
  ) dut_rr (
    .clk (clk), .rst (rst), .req (req), .lock (lock), .we (we),
    .addr (addr), .wdata (wdata), .gnt (gnt_o[0]), .rvalid (rvalid_o[0]),
    .rdata (rdata_o[0]), .ram_addr (ram_addr_o[0]), .ram_data (ram_data_o[0]),
    .ram_we (ram_we_o[0]), .ram_re (ram_re_o[0]), .ram_q (ram_q_i[0]),
    .busy (busy_o[0])
  );

  rf_port_arbiter #(
    .NUM_CLIENTS (N), .ADDR_W (AW), .DATA_W (DW), .RD_LAT (1), .ARB_MODE (0)
  ) dut_fp (
    .clk (clk), .rst (rst), .req (req), .lock (lock), .we (we),
    .addr (addr), .wdata (wdata), .gnt (gnt_o[1]), .rvalid (rvalid_o[1]),
    .rdata (rdata_o[1]), .ram_addr (ram_addr_o[1]), .ram_data (ram_data_o[1]),
    .ram_we (ram_we_o[1]), .ram_re (ram_re_o[1]), .ram_q (ram_q_i[1]),
    .busy (busy_o[1])
  );

  // Behavioural RAMs: read data emerges RD_LAT cycles after the read edge.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (ram_we_o[d]) mem[d][ram_addr_o[d][3:0]] <= ram_data_o[d];
      q_pipe[d][0] <= mem[d][ram_addr_o[d][3:0]];
      q_pipe[d][1] <= q_pipe[d][0];
    end
  end
  assign ram_q_i[0] = q_pipe[0][1];
  assign ram_q_i[1] = q_pipe[1][0];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Winner under the arbitration rules, or -1 for no grant.
  function automatic int pick(input int d);
    int base;
    if (m_owner[d] >= 0) return req[m_owner[d]] ? m_owner[d] : -1;
    base = (mode_of(d) == 1) ? m_ptr[d] : 0;
    for (int k = 0; k < N; k++) begin
      if (req[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic eval();
    for (int d = 0; d < NDUT; d++) begin
      int g;
      g = pick(d);
      e_g[d] = g;
      e_gnt[d] = '0; e_we[d] = 1'b0; e_re[d] = 1'b0; e_addr[d] = '0; e_wd[d] = '0;
      if (g >= 0) begin
        e_gnt[d][g] = 1'b1;
        e_we[d]     = we[g];
        e_re[d]     = !we[g];
        e_addr[d]   = addr[g*AW +: AW];
        e_wd[d]     = wdata[g*DW +: DW];
      end
      e_rv[d] = '0; e_rd[d] = '0;
      e_busy[d] = (m_owner[d] >= 0);
      foreach (pend[i]) begin
        if (pend[i].d == d) begin
          e_busy[d] = 1'b1;
          if (pend[i].due == cyc) begin
            e_rv[d][pend[i].id] = 1'b1;
            e_rd[d] = pend[i].data;
          end
        end
      end
    end
  endtask

  task automatic update();
    rd_exp_t keep [$];
    rd_exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      int g;
      logic [3:0] a;
      g = e_g[d];
      if (g >= 0) begin
        a = addr[g*AW +: 4];
        if (!we[g] && !rst) begin
          e.d = d; e.id = g; e.data = m_mem[d][a]; e.due = cyc + lat_of(d);
          pend.push_back(e);
        end
        if (we[g]) m_mem[d][a] = wdata[g*DW +: DW];
      end
      if (rst) begin
        m_owner[d] = -1;
        m_ptr[d]   = 0;
      end else if (g >= 0) begin
        if (m_owner[d] < 0) begin
          m_ptr[d] = (g + 1) % N;
          if (lock[g]) m_owner[d] = g;
        end else if (!lock[g]) begin
          m_owner[d] = -1;
        end
      end else begin
        m_owner[d] = -1;
      end
    end
    if (rst) pend.delete();
    foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
    pend = keep;
    cyc++;
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = '0; lock = '0; we = '0;
    repeat (n) tick();
  endtask

  task automatic set_addr(input int c, input int a);
    addr[c*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp += 4;
      if (gnt_o[d] !== '0) begin n_bad++; $display("FAIL reset_gnt d%0d: got %b want 0", d, gnt_o[d]); end
      if (rvalid_o[d] !== '0) begin n_bad++; $display("FAIL reset_rvalid d%0d: got %b want 0", d, rvalid_o[d]); end
      if (busy_o[d] !== 1'b0) begin n_bad++; $display("FAIL reset_busy d%0d: got %b want 0", d, busy_o[d]); end
      if ({ram_we_o[d], ram_re_o[d]} !== 2'b00) begin
        n_bad++; $display("FAIL reset_ram_en d%0d: got %b%b want 00", d, ram_we_o[d], ram_re_o[d]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rr_rotation();
    for (int k = 0; k < 8; k++) begin
      req = 4'b1111; lock = '0; we = '0;
      for (int c = 0; c < N; c++) set_addr(c, $urandom_range(0, 15));
      #1;
      n_cmp += 3;
      if (gnt_o[0] !== 4'(1 << (k % 4))) begin
        n_bad++; $display("FAIL rr_gnt k=%0d: got %b want %b", k, gnt_o[0], 4'(1 << (k % 4)));
      end
      if (ram_addr_o[0] !== addr[(k % 4)*AW +: AW]) begin
        n_bad++; $display("FAIL rr_addr k=%0d: got %0d want %0d", k, ram_addr_o[0], addr[(k % 4)*AW +: AW]);
      end
      if (gnt_o[1] !== 4'b0001) begin
        n_bad++; $display("FAIL rr_fixed_gnt k=%0d: got %b want 0001", k, gnt_o[1]);
      end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    idle(3);
    for (int k = 0; k < 3; k++) begin
      req = 4'b1010; we = '0;
      #1; eval();
      n_cmp += 2;
      if (gnt_o[1] !== 4'b0010) begin
        n_bad++; $display("FAIL fixed_gnt k=%0d: got %b want 0010", k, gnt_o[1]);
      end
      if (gnt_o[0] !== e_gnt[0]) begin
        n_bad++; $display("FAIL fixed_rr_gnt k=%0d: got %b want %b", k, gnt_o[0], e_gnt[0]);
      end
      tick();
    end
  endtask

  task automatic test_lock_burst();
    idle(3);
    req = 4'b0010; we = 4'b1111; lock = '0;
    tick();
    for (int b = 0; b < 6; b++) begin
      logic [N-1:0] want_gnt;
      logic         want_busy;
      req  = 4'b0101;
      lock = (b < 4) ? 4'b0100 : 4'b0000;
      want_gnt  = (b < 5) ? 4'b0100 : 4'b0001;
      want_busy = (b >= 1 && b <= 4);
      #1; eval();
      n_cmp += 3;
      if (gnt_o[0] !== want_gnt) begin
        n_bad++; $display("FAIL lock_gnt b=%0d: got %b want %b", b, gnt_o[0], want_gnt);
      end
      if (busy_o[0] !== want_busy) begin
        n_bad++; $display("FAIL lock_busy b=%0d: got %b want %b", b, busy_o[0], want_busy);
      end
      if (gnt_o[1] !== e_gnt[1]) begin
        n_bad++; $display("FAIL lock_fixed_gnt b=%0d: got %b want %b", b, gnt_o[1], e_gnt[1]);
      end
      tick();
    end
  endtask

  task automatic test_read_tagging();
    logic [N-1:0]  req_t [3];
    logic [DW-1:0] exp_dat [NDUT][3];
    req_t[0] = 4'b0010; req_t[1] = 4'b1000; req_t[2] = 4'b0010;
    idle(3);
    for (int k = 0; k < 6; k++) begin
      req = (k < 3) ? req_t[k] : '0; we = '0; lock = '0;
      set_addr(1, $urandom_range(0, 15));
      set_addr(3, $urandom_range(0, 15));
      #1;
      for (int d = 0; d < NDUT; d++) begin
        int i;
        logic [N-1:0] want_rv;
        if (k < 3) exp_dat[d][k] = m_mem[d][(k == 1) ? addr[3*AW +: 4] : addr[1*AW +: 4]];
        i = k - lat_of(d);
        want_rv = (i >= 0 && i < 3) ? req_t[i] : '0;
        n_cmp++;
        if (rvalid_o[d] !== want_rv) begin
          n_bad++; $display("FAIL tag_rvalid d%0d k=%0d: got %b want %b", d, k, rvalid_o[d], want_rv);
        end
        if (i >= 0 && i < 3) begin
          n_cmp++;
          if (rdata_o[d] !== exp_dat[d][i]) begin
            n_bad++; $display("FAIL tag_rdata d%0d k=%0d: got %h want %h", d, k, rdata_o[d], exp_dat[d][i]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    idle(3);
    req = 4'b0100; lock = 4'b0100; we = '0;
    set_addr(2, 5);
    tick();
    #1;
    n_cmp++;
    if (busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", busy_o[0]); end
    tick();
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      for (int d = 0; d < NDUT; d++) begin
        n_cmp += 2;
        if (rvalid_o[d] !== '0) begin n_bad++; $display("FAIL mid_rvalid d%0d k=%0d: got %b want 0", d, k, rvalid_o[d]); end
        if (busy_o[d] !== 1'b0) begin n_bad++; $display("FAIL mid_busy d%0d k=%0d: got %b want 0", d, k, busy_o[d]); end
      end
      tick();
    end
    req = 4'b1111; we = 4'b1111;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (gnt_o[d] !== 4'b0001) begin n_bad++; $display("FAIL mid_next_gnt d%0d: got %b want 0001", d, gnt_o[d]); end
    end
    tick();
  endtask

  task automatic test_lock_drop();
    idle(3);
    req = 4'b0001; lock = 4'b0001; we = 4'b1111;
    tick();
    req = 4'b1110; lock = '0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp += 2;
      if (gnt_o[d] !== 4'b0000) begin n_bad++; $display("FAIL drop_gnt d%0d: got %b want 0000", d, gnt_o[d]); end
      if (busy_o[d] !== 1'b1) begin n_bad++; $display("FAIL drop_busy d%0d: got %b want 1", d, busy_o[d]); end
    end
    tick();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (gnt_o[d] !== 4'b0010) begin n_bad++; $display("FAIL drop_next_gnt d%0d: got %b want 0010", d, gnt_o[d]); end
    end
    tick();
    idle(3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = N'($urandom);
      lock = N'($urandom) & N'($urandom);
      we   = N'($urandom);
      for (int c = 0; c < N; c++) begin
        set_addr(c, $urandom_range(0, 15));
        wdata[c*DW +: DW] = {$urandom, $urandom};
      end
      #1; eval();
      for (int d = 0; d < NDUT; d++) begin
        n_cmp += 7;
        if (gnt_o[d] !== e_gnt[d]) begin n_bad++; $display("FAIL rnd_gnt d%0d k=%0d: got %b want %b", d, k, gnt_o[d], e_gnt[d]); end
        if (ram_we_o[d] !== e_we[d]) begin n_bad++; $display("FAIL rnd_ram_we d%0d k=%0d: got %b want %b", d, k, ram_we_o[d], e_we[d]); end
        if (ram_re_o[d] !== e_re[d]) begin n_bad++; $display("FAIL rnd_ram_re d%0d k=%0d: got %b want %b", d, k, ram_re_o[d], e_re[d]); end
        if (ram_addr_o[d] !== e_addr[d]) begin n_bad++; $display("FAIL rnd_ram_addr d%0d k=%0d: got %0d want %0d", d, k, ram_addr_o[d], e_addr[d]); end
        if (ram_data_o[d] !== e_wd[d]) begin n_bad++; $display("FAIL rnd_ram_data d%0d k=%0d: got %h want %h", d, k, ram_data_o[d], e_wd[d]); end
        if (rvalid_o[d] !== e_rv[d]) begin n_bad++; $display("FAIL rnd_rvalid d%0d k=%0d: got %b want %b", d, k, rvalid_o[d], e_rv[d]); end
        if (busy_o[d] !== e_busy[d]) begin n_bad++; $display("FAIL rnd_busy d%0d k=%0d: got %b want %b", d, k, busy_o[d], e_busy[d]); end
        if (e_rv[d] != '0) begin
          n_cmp++;
          if (rdata_o[d] !== e_rd[d]) begin n_bad++; $display("FAIL rnd_rdata d%0d k=%0d: got %h want %h", d, k, rdata_o[d], e_rd[d]); end
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    cyc = 0;
    for (int d = 0; d < NDUT; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
    end
    for (int a = 0; a < 16; a++) begin
      logic [DW-1:0] v;
      v = {$urandom, $urandom};
      for (int d = 0; d < NDUT; d++) begin
        mem[d][a]   = v;
        m_mem[d][a] = v;
      end
    end
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_lock_burst();
    test_read_tagging();
    test_reset_midflight();
    test_lock_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
